hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX/ID forwarding selects, load/branch/MDU stall detection,
// multi-cycle MDU busy tracker and a saturating stalled-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] writereg_ex,
  input  logic [REG_AW-1:0] writereg_mem,
  input  logic [REG_AW-1:0] writereg_wb,
  input  logic              regwrite_ex,
  input  logic              regwrite_mem,
  input  logic              regwrite_wb,
  input  logic              memtoreg_ex,
  input  logic              memtoreg_mem,
  input  logic              branch_id,
  input  logic              mdu_req_id,
  input  logic              mdu_start_ex,
  input  logic              mdu_div_ex,
  input  logic              stall_cnt_clr,
  output logic [1:0]        forward_a_ex,
  output logic [1:0]        forward_b_ex,
  output logic              forward_a_id,
  output logic              forward_b_id,
  output logic              en_if,
  output logic              en_id,
  output logic              flush_ex,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Counter only has to hold DIV_CYCLES-2, the larger of the two reload values.
  localparam int unsigned MDU_CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [MDU_CW-1:0] DIV_LOAD = MDU_CW'(DIV_CYCLES - 2);
  localparam logic [MDU_CW-1:0] MUL_LOAD = MDU_CW'(MUL_CYCLES - 2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MDU_CW-1:0]  r_cnt;
  logic [MDU_CW-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_wb_hit_a, w_wb_hit_b, w_mem_hit_a, w_mem_hit_b;
  logic w_ex_hit_id, w_mem_hit_id;
  logic w_lwstall, w_brstall, w_mdustall, w_stall;

  // EX-stage forwarding; MEM result is younger so it takes priority over WB.
  always_comb begin
    w_mem_hit_a = (rs_ex != '0) && (rs_ex == writereg_mem) && regwrite_mem;
    w_mem_hit_b = (rt_ex != '0) && (rt_ex == writereg_mem) && regwrite_mem;
    w_wb_hit_a  = (rs_ex != '0) && (rs_ex == writereg_wb)  && regwrite_wb;
    w_wb_hit_b  = (rt_ex != '0) && (rt_ex == writereg_wb)  && regwrite_wb;

    forward_a_ex = 2'b00;
    if (w_mem_hit_a)     forward_a_ex = 2'b10;
    else if (w_wb_hit_a) forward_a_ex = 2'b01;

    forward_b_ex = 2'b00;
    if (w_mem_hit_b)     forward_b_ex = 2'b10;
    else if (w_wb_hit_b) forward_b_ex = 2'b01;
  end

  // ID-stage branch compare can only pick up a finished MEM-stage ALU result.
  always_comb begin
    forward_a_id = (rs_id != '0) && (rs_id == writereg_mem) && regwrite_mem;
    forward_b_id = (rt_id != '0) && (rt_id == writereg_mem) && regwrite_mem;
  end

  always_comb begin
    w_ex_hit_id  = (writereg_ex != '0) &&
                   ((writereg_ex == rs_id) || (writereg_ex == rt_id));
    w_mem_hit_id = (writereg_mem != '0) &&
                   ((writereg_mem == rs_id) || (writereg_mem == rt_id));

    w_lwstall  = memtoreg_ex && w_ex_hit_id;
    w_brstall  = branch_id && ((regwrite_ex && w_ex_hit_id) ||
                               (memtoreg_mem && w_mem_hit_id));
    w_mdustall = mdu_req_id && (mdu_busy || mdu_start_ex);
    w_stall    = w_lwstall || w_brstall || w_mdustall;

    en_if    = ~w_stall;
    en_id    = ~w_stall;
    flush_ex = w_stall;
  end

  // MDU tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Start cycle counts as the first latency cycle, hence the LAT-2 reload.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mdu_start_ex) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = mdu_div_ex ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - MDU_CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign mdu_busy = (r_state == S_RUN);

  // Saturating stalled-cycle counter; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stall sources, MDU timing,
// stall counter saturation/clear and asynchronous reset.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex;
  logic [REG_AW-1:0] writereg_ex, writereg_mem, writereg_wb;
  logic              regwrite_ex, regwrite_mem, regwrite_wb;
  logic              memtoreg_ex, memtoreg_mem, branch_id;
  logic              mdu_req_id, mdu_start_ex, mdu_div_ex, stall_cnt_clr;
  logic [1:0]        forward_a_ex, forward_b_ex;
  logic              forward_a_id, forward_b_id;
  logic              en_if, en_id, flush_ex, mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int passed = 0;

  hazard_ctrl #(
    .REG_AW(REG_AW), .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .writereg_ex(writereg_ex), .writereg_mem(writereg_mem), .writereg_wb(writereg_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memtoreg_ex(memtoreg_ex), .memtoreg_mem(memtoreg_mem), .branch_id(branch_id),
    .mdu_req_id(mdu_req_id), .mdu_start_ex(mdu_start_ex), .mdu_div_ex(mdu_div_ex),
    .stall_cnt_clr(stall_cnt_clr),
    .forward_a_ex(forward_a_ex), .forward_b_ex(forward_b_ex),
    .forward_a_id(forward_a_id), .forward_b_id(forward_b_id),
    .en_if(en_if), .en_id(en_id), .flush_ex(flush_ex),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
    writereg_ex = '0; writereg_mem = '0; writereg_wb = '0;
    regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    memtoreg_ex = 0; memtoreg_mem = 0; branch_id = 0;
    mdu_req_id = 0; mdu_start_ex = 0; mdu_div_ex = 0; stall_cnt_clr = 0;
  endtask

  task automatic clear_cnt();
    stall_cnt_clr = 1;
    tick();
    stall_cnt_clr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    checks++;
    if ({forward_a_ex, forward_b_ex, forward_a_id, forward_b_id, en_if, en_id, flush_ex, mdu_busy} !== 10'b0000_00_1_1_0_0)
      $display("FAIL reset_outputs: got fa=%b fb=%b fia=%b fib=%b en_if=%b en_id=%b flush=%b busy=%b, want 00 00 0 0 1 1 0 0",
               forward_a_ex, forward_b_ex, forward_a_id, forward_b_id, en_if, en_id, flush_ex, mdu_busy);
    else passed++;
    checks++;
    if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    else passed++;
    tick();
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (en_if !== 1'b1 || flush_ex !== 1'b0 || mdu_busy !== 1'b0 || stall_cnt !== '0)
      $display("FAIL post_reset_idle: en_if=%b flush=%b busy=%b cnt=%0d, want 1 0 0 0",
               en_if, flush_ex, mdu_busy, stall_cnt);
    else passed++;
  endtask

  task automatic test_fwd_ex();
    clear_inputs();
    rs_ex = 3; writereg_mem = 3; regwrite_mem = 1; writereg_wb = 3; regwrite_wb = 1;
    #1;
    checks++;
    if (forward_a_ex !== 2'b10) $display("FAIL fwd_a_mem_priority: got %b want 10", forward_a_ex);
    else passed++;
    regwrite_mem = 0;
    #1;
    checks++;
    if (forward_a_ex !== 2'b01) $display("FAIL fwd_a_wb: got %b want 01", forward_a_ex);
    else passed++;
    rs_ex = 0; writereg_mem = 0; writereg_wb = 0; regwrite_mem = 1;
    #1;
    checks++;
    if (forward_a_ex !== 2'b00) $display("FAIL fwd_a_zero_reg: got %b want 00", forward_a_ex);
    else passed++;
    rt_ex = 9; writereg_mem = 9; writereg_wb = 4; rs_ex = 4;
    #1;
    checks++;
    if (forward_b_ex !== 2'b10 || forward_a_ex !== 2'b01)
      $display("FAIL fwd_b_mem_a_wb: got a=%b b=%b want a=01 b=10", forward_a_ex, forward_b_ex);
    else passed++;
    regwrite_mem = 0; regwrite_wb = 0;
    #1;
    checks++;
    if (forward_b_ex !== 2'b00 || forward_a_ex !== 2'b00)
      $display("FAIL fwd_no_write: got a=%b b=%b want 00 00", forward_a_ex, forward_b_ex);
    else passed++;
  endtask

  task automatic test_fwd_id();
    clear_inputs();
    rs_id = 6; rt_id = 8; writereg_mem = 8; regwrite_mem = 1;
    #1;
    checks++;
    if (forward_a_id !== 1'b0 || forward_b_id !== 1'b1)
      $display("FAIL fwd_id_b: got a=%b b=%b want 0 1", forward_a_id, forward_b_id);
    else passed++;
    rt_id = 0; writereg_mem = 0;
    #1;
    checks++;
    if (forward_b_id !== 1'b0) $display("FAIL fwd_id_zero_reg: got %b want 0", forward_b_id);
    else passed++;
  endtask

  task automatic test_lwstall();
    clear_inputs();
    clear_cnt();
    memtoreg_ex = 1; writereg_ex = 5; rt_id = 5;
    #1;
    checks++;
    if (en_if !== 1'b0 || en_id !== 1'b0 || flush_ex !== 1'b1)
      $display("FAIL lwstall_assert: en_if=%b en_id=%b flush=%b want 0 0 1", en_if, en_id, flush_ex);
    else passed++;
    tick(); tick(); tick();
    checks++;
    if (stall_cnt !== CNT_W'(3)) $display("FAIL lwstall_count: got %0d want 3", stall_cnt);
    else passed++;
    writereg_ex = 0; rt_id = 0;
    #1;
    checks++;
    if (en_if !== 1'b1 || flush_ex !== 1'b0)
      $display("FAIL lwstall_zero_reg: en_if=%b flush=%b want 1 0", en_if, flush_ex);
    else passed++;
    tick();
    checks++;
    if (stall_cnt !== CNT_W'(3)) $display("FAIL lwstall_count_hold: got %0d want 3", stall_cnt);
    else passed++;
  endtask

  task automatic test_brstall();
    clear_inputs();
    branch_id = 1; rs_id = 7; regwrite_ex = 1; writereg_ex = 7;
    #1;
    checks++;
    if (en_id !== 1'b0 || flush_ex !== 1'b1)
      $display("FAIL brstall_ex: en_id=%b flush=%b want 0 1", en_id, flush_ex);
    else passed++;
    tick();
    regwrite_ex = 0; writereg_ex = 0;
    memtoreg_mem = 0; writereg_mem = 7; regwrite_mem = 1;
    #1;
    checks++;
    if (en_id !== 1'b1 || flush_ex !== 1'b0 || forward_a_id !== 1'b1)
      $display("FAIL brstall_release: en_id=%b flush=%b fwd_a_id=%b want 1 0 1", en_id, flush_ex, forward_a_id);
    else passed++;
    memtoreg_mem = 1;
    #1;
    checks++;
    if (en_if !== 1'b0) $display("FAIL brstall_load_mem: en_if=%b want 0", en_if);
    else passed++;
    branch_id = 0;
    #1;
    checks++;
    if (en_if !== 1'b1) $display("FAIL brstall_no_branch: en_if=%b want 1", en_if);
    else passed++;
    tick();
  endtask

  // Counts stalled cycles from the start cycle until the MDU stall releases.
  task automatic run_mdu(input logic div, input logic restart, input int exp_stall,
                         input int exp_busy, input string name);
    int stalls;
    int busy;
    int guard;
    clear_inputs();
    mdu_req_id = 1; mdu_start_ex = 1; mdu_div_ex = div;
    #1;
    stalls = (en_if === 1'b0) ? 1 : 0;
    busy = 0;
    guard = 0;
    tick();
    mdu_start_ex = restart; mdu_div_ex = 1;
    while (mdu_busy === 1'b1 && guard < 100) begin
      busy++;
      if (en_if === 1'b0) stalls++;
      tick();
      mdu_start_ex = 0;
      guard++;
    end
    checks++;
    if (guard >= 100) $display("FAIL %s_timeout: busy never fell within 100 cycles", name);
    else passed++;
    checks++;
    if (stalls !== exp_stall || busy !== exp_busy)
      $display("FAIL %s_cycles: stall=%0d busy=%0d want stall=%0d busy=%0d", name, stalls, busy, exp_stall, exp_busy);
    else passed++;
    checks++;
    if (en_if !== 1'b1) $display("FAIL %s_release: en_if=%b want 1", name, en_if);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_mdu();
    run_mdu(1'b1, 1'b0, 32, 31, "mdu_div");
    run_mdu(1'b0, 1'b1, 4, 3, "mdu_mul_restart");
  endtask

  task automatic test_stall_cnt_sat();
    clear_inputs();
    clear_cnt();
    memtoreg_ex = 1; writereg_ex = 2; rs_id = 2;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (stall_cnt !== '1) $display("FAIL stall_cnt_saturate: got %0d want %0d", stall_cnt, (1 << CNT_W) - 1);
    else passed++;
    stall_cnt_clr = 1;
    tick();
    checks++;
    if (stall_cnt !== '0) $display("FAIL stall_cnt_clr_wins: got %0d want 0", stall_cnt);
    else passed++;
    stall_cnt_clr = 0;
    tick();
    checks++;
    if (stall_cnt !== CNT_W'(1)) $display("FAIL stall_cnt_after_clr: got %0d want 1", stall_cnt);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_div();
    clear_inputs();
    mdu_start_ex = 1; mdu_div_ex = 1; mdu_req_id = 1;
    tick();
    mdu_start_ex = 0;
    tick(); tick();
    checks++;
    if (mdu_busy !== 1'b1 || stall_cnt === '0)
      $display("FAIL mid_div_precond: busy=%b cnt=%0d want busy=1 cnt>0", mdu_busy, stall_cnt);
    else passed++;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || stall_cnt !== '0 || en_if !== 1'b1)
      $display("FAIL async_reset: busy=%b cnt=%0d en_if=%b want 0 0 1", mdu_busy, stall_cnt, en_if);
    else passed++;
    mdu_req_id = 0;
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (mdu_busy !== 1'b0) $display("FAIL post_abort_idle: busy=%b want 0", mdu_busy);
    else passed++;
    mdu_start_ex = 1; mdu_div_ex = 0;
    tick();
    mdu_start_ex = 0;
    checks++;
    if (mdu_busy !== 1'b1) $display("FAIL post_abort_start: busy=%b want 1", mdu_busy);
    else passed++;
    tick(); tick(); tick();
    checks++;
    if (mdu_busy !== 1'b0) $display("FAIL post_abort_mul_done: busy=%b want 0", mdu_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_id();
    test_lwstall();
    test_brstall();
    test_mdu();
    test_stall_cnt_sat();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
